matrix_operand_loader: RTL and testbench

//  Upstream operand stage for the matrix adder. Accepts the HPS write stream as 32-bit words
//  (4 signed 8-bit elements each) over a valid/ready handshake. Assembles dense row-major

---
 rtl/matrix_pkg.sv | 43 ++++
 rtl/word_to_elem_packer.sv | 28 ++
 rtl/matrix_operand_loader.sv | 135 +++++++++++++
 tb/tb_matrix_operand_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and size tables for the matrix operand loader and its packer.
// Pure declarations: no latency and no flow control of its own.
package matrix_pkg;

    localparam int ELEM_W        = 8;
    localparam int MAX_ELEM      = 25;
    localparam int WORD_W        = 32;
    localparam int ELEM_PER_WORD = WORD_W / ELEM_W;
    localparam int MAT_W         = ELEM_W * MAX_ELEM;
    localparam int IDX_W         = 5;
    localparam int WCNT_W        = 3;

    localparam logic [1:0] SZ_2X2 = 2'b00;
    localparam logic [1:0] SZ_3X3 = 2'b01;
    localparam logic [1:0] SZ_4X4 = 2'b10;
    localparam logic [1:0] SZ_5X5 = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    function automatic logic [IDX_W-1:0] n_elem(input logic [1:0] size);
        case (size)
            SZ_2X2:  return 5'd4;
            SZ_3X3:  return 5'd9;
            SZ_4X4:  return 5'd16;
            default: return 5'd25;
        endcase
    endfunction

    function automatic logic [WCNT_W-1:0] words_per_matrix(input logic [1:0] size);
        case (size)
            SZ_2X2:  return 3'd1;
            SZ_3X3:  return 3'd3;
            SZ_4X4:  return 3'd4;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/word_to_elem_packer.sv
// Maps one input word onto the element slots it fills; bytes at or past n_elem are dropped.
// Purely combinational, no backpressure: the caller qualifies the mask with its transfer strobe.
module word_to_elem_packer
    import matrix_pkg::*;
(
    input  logic [IDX_W-1:0]    elem_idx,
    input  logic [IDX_W-1:0]    elem_lim,
    input  logic [WORD_W-1:0]   wr_data,
    output logic [MAX_ELEM-1:0] slot_mask,
    output logic [MAT_W-1:0]    slot_data
);

    logic [IDX_W:0] slot [ELEM_PER_WORD];

    always_comb begin
        slot_mask = '0;
        slot_data = '0;
        for (int k = 0; k < ELEM_PER_WORD; k++) begin
            slot[k] = {1'b0, elem_idx} + (IDX_W+1)'(k);
            // elem_lim never exceeds MAX_ELEM, so a passing slot always fits IDX_W bits
            if (slot[k] < {1'b0, elem_lim}) begin
                slot_mask[slot[k][IDX_W-1:0]] = 1'b1;
                slot_data[slot[k][IDX_W-1:0]*ELEM_W +: ELEM_W] = wr_data[k*ELEM_W +: ELEM_W];
            end
        end
    end

endmodule

// File: rtl/matrix_operand_loader.sv
// Assembles matrix A then B from a 32-bit word stream and holds them until acknowledged.
// Last B word in cycle t gives operands_valid at t+1; wr_ready is high only while loading and drops on abort.
module matrix_operand_loader
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        matrix_size,
    input  logic              wr_valid,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [MAT_W-1:0]  matrix_A,
    output logic [MAT_W-1:0]  matrix_B,
    output logic [1:0]        size_out,
    output logic              operands_valid,
    input  logic              operands_ack,
    output logic              busy,
    output logic              error
);

    state_t              state;
    state_t              state_nxt;
    logic [WCNT_W-1:0]   word_cnt;
    logic [IDX_W-1:0]    elem_idx;
    logic [WCNT_W-1:0]   wpm;
    logic [IDX_W-1:0]    elem_lim;
    logic                xfer;
    logic                last_word;
    logic [MAX_ELEM-1:0] slot_mask;
    logic [MAT_W-1:0]    slot_data;
    logic [MAT_W-1:0]    merged;

    assign wpm            = words_per_matrix(size_out);
    assign elem_lim       = n_elem(size_out);
    assign wr_ready       = ((state == LOAD_A) || (state == LOAD_B)) && !abort;
    assign xfer           = wr_valid && wr_ready;
    assign last_word      = (word_cnt == (wpm - WCNT_W'(1)));
    assign operands_valid = (state == HOLD);
    assign busy           = (state != IDLE);

    word_to_elem_packer u_packer (
        .elem_idx  (elem_idx),
        .elem_lim  (elem_lim),
        .wr_data   (wr_data),
        .slot_mask (slot_mask),
        .slot_data (slot_data)
    );

    // Merge the new bytes into whichever matrix is being filled right now.
    always_comb begin
        merged = (state == LOAD_B) ? matrix_B : matrix_A;
        for (int i = 0; i < MAX_ELEM; i++) begin
            if (slot_mask[i]) begin
                merged[i*ELEM_W +: ELEM_W] = slot_data[i*ELEM_W +: ELEM_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)                state_nxt = LOAD_A;
                LOAD_A:  if (xfer && last_word)    state_nxt = LOAD_B;
                LOAD_B:  if (xfer && last_word)    state_nxt = HOLD;
                HOLD:    if (operands_ack)         state_nxt = IDLE;
                default:                           state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            matrix_A <= '0;
            matrix_B <= '0;
            size_out <= '0;
            word_cnt <= '0;
            elem_idx <= '0;
            error    <= 1'b0;
        end else begin
            error <= 1'b0;
            if (abort) begin
                matrix_A <= '0;
                matrix_B <= '0;
                word_cnt <= '0;
                elem_idx <= '0;
            end else begin
                if (start && (state != IDLE)) begin
                    error <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (start) begin
                            size_out <= matrix_size;
                            matrix_A <= '0;
                            matrix_B <= '0;
                            word_cnt <= '0;
                            elem_idx <= '0;
                        end
                    end
                    LOAD_A, LOAD_B: begin
                        if (xfer) begin
                            if (state == LOAD_A) begin
                                matrix_A <= merged;
                            end else begin
                                matrix_B <= merged;
                            end
                            if (last_word) begin
                                word_cnt <= '0;
                                elem_idx <= '0;
                            end else begin
                                word_cnt <= word_cnt + WCNT_W'(1);
                                elem_idx <= elem_idx + IDX_W'(ELEM_PER_WORD);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader: hand-computed operand images and handshake checks.
module tb_matrix_operand_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [1:0]   matrix_size = 2'b00;
    logic         wr_valid = 1'b0;
    logic [31:0]  wr_data = 32'h0;
    logic         wr_ready;
    logic [199:0] matrix_A;
    logic [199:0] matrix_B;
    logic [1:0]   size_out;
    logic         operands_valid;
    logic         operands_ack = 1'b0;
    logic         busy;
    logic         error;

    int n_cmp = 0;
    int n_bad = 0;
    int xfers = 0;

    matrix_operand_loader dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .matrix_size    (matrix_size),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .matrix_A       (matrix_A),
        .matrix_B       (matrix_B),
        .size_out       (size_out),
        .operands_valid (operands_valid),
        .operands_ack   (operands_ack),
        .busy           (busy),
        .error          (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_valid && wr_ready) xfers <= xfers + 1;
    end

    task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] sz);
        start       = 1'b1;
        matrix_size = sz;
        @(negedge clk);
        start       = 1'b0;
        matrix_size = ~sz;
    endtask

    // Holds the word until a rising edge sees wr_ready, then releases at the following negedge.
    task automatic send_word(input logic [31:0] d, input int gap);
        bit done;
        int t;
        wr_valid = 1'b0;
        repeat (gap) @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = d;
        done = 1'b0;
        t = 0;
        while (!done && t < 40) begin
            done = wr_ready;
            @(negedge clk);
            t++;
        end
        wr_valid = 1'b0;
        if (!done) chk("wr_ready_timeout", 200'(0), 200'(1));
    endtask

    task automatic ack_op();
        operands_ack = 1'b1;
        @(negedge clk);
        operands_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [199:0] ea;
        logic [199:0] eb;
        logic [31:0]  w;
        int           x0;

        repeat (2) @(negedge clk);
        chk("rst_wr_ready", 200'(wr_ready), 200'(0));
        chk("rst_busy",     200'(busy), 200'(0));
        chk("rst_valid",    200'(operands_valid), 200'(0));
        chk("rst_error",    200'(error), 200'(0));
        chk("rst_A",        matrix_A, 200'(0));
        chk("rst_B",        matrix_B, 200'(0));
        chk("rst_size",     200'(size_out), 200'(0));
        reset = 1'b0;
        @(negedge clk);

        // 2x2 back-to-back: valid three cycles after start
        x0 = xfers;
        do_start(2'b00);
        chk("t1_busy", 200'(busy), 200'(1));
        send_word(32'h04030201, 0);
        chk("t1_valid_early", 200'(operands_valid), 200'(0));
        send_word(32'h08070605, 0);
        chk("t1_valid", 200'(operands_valid), 200'(1));
        chk("t1_A", matrix_A, 200'h04030201);
        chk("t1_B", matrix_B, 200'h08070605);
        chk("t1_xfers", 200'(xfers - x0), 200'(2));
        repeat (3) @(negedge clk);
        chk("t1_valid_held", 200'(operands_valid), 200'(1));
        chk("t1_wr_ready_hold", 200'(wr_ready), 200'(0));
        ack_op();
        chk("t1_valid_after_ack", 200'(operands_valid), 200'(0));
        chk("t1_busy_after_ack", 200'(busy), 200'(0));
        chk("t1_A_kept", matrix_A, 200'h04030201);

        // 3x3 with gaps; bytes past element 8 dropped
        x0 = xfers;
        do_start(2'b01);
        send_word(32'h04030201, $urandom_range(0, 3));
        send_word(32'h08070605, $urandom_range(0, 3));
        send_word(32'hAABBCC09, $urandom_range(0, 3));
        send_word(32'h14131211, $urandom_range(0, 3));
        send_word(32'h18171615, $urandom_range(0, 3));
        send_word(32'hAABBCC09, $urandom_range(0, 3));
        chk("t2_valid", 200'(operands_valid), 200'(1));
        chk("t2_A", matrix_A, 200'h09_08070605_04030201);
        chk("t2_B", matrix_B, 200'h09_18171615_14131211);
        chk("t2_xfers", 200'(xfers - x0), 200'(6));
        chk("t2_size", 200'(size_out), 200'(1));
        ack_op();

        // 5x5 negative values, long hold with a word offered
        x0 = xfers;
        ea = '0;
        eb = '0;
        for (int i = 0; i < 25; i++) begin
            ea[i*8 +: 8] = 8'(128 + i);
            eb[i*8 +: 8] = 8'(152 - i);
        end
        do_start(2'b11);
        for (int j = 0; j < 7; j++) begin
            for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(128 + 4*j + k);
            send_word(w, 0);
        end
        for (int j = 0; j < 7; j++) begin
            for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(152 - (4*j + k));
            send_word(w, 1);
        end
        chk("t3_xfers", 200'(xfers - x0), 200'(14));
        wr_valid = 1'b1;
        wr_data  = 32'hFFFFFFFF;
        for (int c = 0; c < 10; c++) begin
            chk("t3_hold_valid", 200'(operands_valid), 200'(1));
            chk("t3_hold_ready", 200'(wr_ready), 200'(0));
            chk("t3_hold_A", matrix_A, ea);
            chk("t3_hold_B", matrix_B, eb);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        chk("t3_xfers_hold", 200'(xfers - x0), 200'(14));
        ack_op();

        // start during LOAD_B
        do_start(2'b01);
        send_word(32'h11111111, 0);
        send_word(32'h22222222, 0);
        send_word(32'h33333333, 0);
        send_word(32'h44444444, 0);
        start       = 1'b1;
        matrix_size = 2'b11;
        @(negedge clk);
        start = 1'b0;
        chk("t4_error_pulse", 200'(error), 200'(1));
        @(negedge clk);
        chk("t4_error_clear", 200'(error), 200'(0));
        chk("t4_size", 200'(size_out), 200'(1));
        chk("t4_busy", 200'(busy), 200'(1));
        send_word(32'h55555555, 0);
        send_word(32'h66666666, 0);
        chk("t4_valid", 200'(operands_valid), 200'(1));
        chk("t4_A", matrix_A, 200'h33_22222222_11111111);
        chk("t4_B", matrix_B, 200'h66_55555555_44444444);
        ack_op();

        // abort mid-A on 4x4, then a clean 2x2
        do_start(2'b10);
        x0 = xfers;
        send_word(32'hDEADBEEF, 0);
        send_word(32'hCAFEF00D, 0);
        abort    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'hFFFFFFFF;
        #1;
        chk("t5_ready_abort", 200'(wr_ready), 200'(0));
        @(negedge clk);
        abort    = 1'b0;
        wr_valid = 1'b0;
        chk("t5_busy", 200'(busy), 200'(0));
        chk("t5_A_zero", matrix_A, 200'(0));
        chk("t5_B_zero", matrix_B, 200'(0));
        chk("t5_xfers", 200'(xfers - x0), 200'(2));
        chk("t5_valid", 200'(operands_valid), 200'(0));
        do_start(2'b00);
        send_word(32'h11223344, 0);
        send_word(32'h55667788, 0);
        chk("t5_new_valid", 200'(operands_valid), 200'(1));
        chk("t5_new_A", matrix_A, 200'h11223344);
        chk("t5_new_B", matrix_B, 200'h55667788);
        chk("t5_new_size", 200'(size_out), 200'(0));

        // async reset in HOLD, away from any edge
        chk("t6_in_hold", 200'(operands_valid), 200'(1));
        #2 reset = 1'b1;
        #1;
        chk("t6_A", matrix_A, 200'(0));
        chk("t6_B", matrix_B, 200'(0));
        chk("t6_valid", 200'(operands_valid), 200'(0));
        chk("t6_busy", 200'(busy), 200'(0));
        chk("t6_ready", 200'(wr_ready), 200'(0));
        @(negedge clk);
        reset = 1'b0;
        x0 = xfers;
        wr_valid = 1'b1;
        wr_data  = 32'h12345678;
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_accept", 200'(wr_ready), 200'(0));
        end
        wr_valid = 1'b0;
        chk("t6_xfers", 200'(xfers - x0), 200'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
